// File: rtl/serial_display_pkg.sv
// Shared constants and sizing helpers for the 3-wire serial display link,
// used by both the transmitter and the receiver side.
package serial_display_pkg;

  localparam int DEF_NUM_DIGITS     = 4;
  localparam int DEF_BITS_PER_DIGIT = 8;

  function automatic int frame_bits(input int num_digits, input int bits_per_digit);
    return num_digits * bits_per_digit;
  endfunction

  // Bit counter must represent 0..FRAME_BITS+1 (the +1 marks an overrun).
  function automatic int count_w(input int num_digits, input int bits_per_digit);
    return $clog2(frame_bits(num_digits, bits_per_digit) + 2);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous line, with a rising-edge pulse
// derived from the synchronized level.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_p;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
      prev   <= 1'b0;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], d};
      prev   <= sync_p[STAGES-1];
    end
  end

  assign level = sync_p[STAGES-1];
  assign rise  = sync_p[STAGES-1] & ~prev;

endmodule

// File: rtl/serial_display_receiver.sv
// Receiving end of the serial display link: shift chain plus output latch,
// oversampled in the system clock domain.
module serial_display_receiver
  import serial_display_pkg::*;
#(
  parameter int NUM_DIGITS     = DEF_NUM_DIGITS,
  parameter int BITS_PER_DIGIT = DEF_BITS_PER_DIGIT,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                                               i_clk,
  input  logic                                               i_reset_n,
  input  logic                                               i_en,
  input  logic                                               i_serial_data,
  input  logic                                               i_serial_latch,
  input  logic                                               i_serial_clk,
  output logic [NUM_DIGITS*BITS_PER_DIGIT-1:0]               o_segments,
  output logic                                               o_frame_strobe,
  output logic                                               o_frame_error,
  output logic [count_w(NUM_DIGITS, BITS_PER_DIGIT)-1:0]     o_bit_count
);

  localparam int FRAME_BITS = frame_bits(NUM_DIGITS, BITS_PER_DIGIT);
  localparam int CNT_W      = count_w(NUM_DIGITS, BITS_PER_DIGIT);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic data_level, data_rise;
  logic sclk_level, sclk_rise;
  logic latch_level, latch_rise;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .d     (i_serial_data),
    .level (data_level),
    .rise  (data_rise)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .d     (i_serial_clk),
    .level (sclk_level),
    .rise  (sclk_rise)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_latch (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .d     (i_serial_latch),
    .level (latch_level),
    .rise  (latch_rise)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, data_rise, sclk_level, latch_level};

  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS-1:0] shift_nxt;
  logic [CNT_W-1:0]      bit_count;
  logic [CNT_W-1:0]      count_nxt;
  logic                  do_latch;

  // Shift is resolved first so a latch in the same cycle sees the new bit.
  always_comb begin
    shift_nxt = shift_reg;
    count_nxt = bit_count;
    if (i_en && sclk_rise) begin
      shift_nxt = {shift_reg[FRAME_BITS-2:0], data_level};
      if (bit_count != CNT_SAT) begin
        count_nxt = bit_count + 1'b1;
      end
    end
  end

  assign do_latch = i_en & latch_rise;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shift_reg      <= '0;
      bit_count      <= '0;
      o_segments     <= '0;
      o_frame_strobe <= 1'b0;
      o_frame_error  <= 1'b0;
    end else begin
      shift_reg      <= shift_nxt;
      o_frame_strobe <= 1'b0;
      if (do_latch) begin
        bit_count <= '0;
        if (count_nxt == CNT_FULL) begin
          o_segments     <= shift_nxt;
          o_frame_strobe <= 1'b1;
          o_frame_error  <= 1'b0;
        end else begin
          o_frame_error  <= 1'b1;
        end
      end else begin
        bit_count <= count_nxt;
      end
    end
  end

  assign o_bit_count = bit_count;

endmodule
